// File: rtl/nv_nvdla_sdp_core_varpack.sv
// Serializes one IW-bit word into up to NSEG OW-bit segments, in LSB- or MSB-first order.
// Optional perf counters are built when NVDLA_SDP_VARPACK_PERF_EN is defined.
module nv_nvdla_sdp_core_varpack #(
  parameter  int IW   = 512,
  parameter  int OW   = 128,
  localparam int NSEG = IW / OW,
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          inp_pvld,
  output logic          inp_prdy,
  input  logic [IW-1:0] inp_data,
  input  logic [CW:0]   inp_nseg,
  input  logic          inp_msb_first,
  output logic          out_pvld,
  input  logic          out_prdy,
  output logic [OW-1:0] out_data,
  output logic [CW-1:0] out_idx,
  output logic          out_last
`ifdef NVDLA_SDP_VARPACK_PERF_EN
  ,
  input  logic          perf_clr,
  output logic [31:0]   perf_seg_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);

  if ((IW % OW) != 0 || !(NSEG == 1 || NSEG == 2 || NSEG == 4 || NSEG == 8 || NSEG == 16)) begin : g_cfg_err
    $error("varpack: IW must be OW times 1, 2, 4, 8 or 16");
  end

  localparam logic [CW:0] NSEG_W = (CW+1)'(NSEG);

  logic                     hold_vld_q;
  logic [NSEG-1:0][OW-1:0]  data_q;
  logic [CW:0]              nseg_q, nseg_d;
  logic                     msb_q;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [CW:0]              cnt_ext, last_cnt, idx_full;
  logic                     inp_acc, out_acc;

  // Out-of-range segment counts mean "whole word".
  always_comb begin
    nseg_d = inp_nseg;
    if (inp_nseg == '0 || inp_nseg > NSEG_W) nseg_d = NSEG_W;
  end

  assign cnt_ext  = {1'b0, cnt_q};
  assign last_cnt = nseg_q - (CW+1)'(1);
  assign idx_full = msb_q ? (last_cnt - cnt_ext) : cnt_ext;

  assign out_pvld = hold_vld_q;
  assign out_last = hold_vld_q & (cnt_ext == last_cnt);
  assign out_idx  = hold_vld_q ? idx_full[CW-1:0] : '0;
  assign out_data = hold_vld_q ? data_q[out_idx] : '0;

  // Refill on the last beat handshake so back-to-back words stream without a bubble.
  assign inp_prdy = ~hold_vld_q | (out_prdy & out_last);
  assign inp_acc  = inp_pvld & inp_prdy;
  assign out_acc  = hold_vld_q & out_prdy;

  always_comb begin
    cnt_d = cnt_q;
    if (inp_acc)      cnt_d = '0;
    else if (out_acc) cnt_d = out_last ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      hold_vld_q <= 1'b0;
      cnt_q      <= '0;
      nseg_q     <= NSEG_W;
      msb_q      <= 1'b0;
    end else begin
      if (inp_prdy) hold_vld_q <= inp_pvld;
      if (inp_acc) begin
        nseg_q <= nseg_d;
        msb_q  <= inp_msb_first;
      end
      cnt_q <= cnt_d;
    end
  end

  // Payload carries no reset; it is only observed while hold_vld_q is set.
  always_ff @(posedge nvdla_core_clk) begin
    if (inp_acc) data_q <= inp_data;
  end

`ifdef NVDLA_SDP_VARPACK_PERF_EN
  logic [31:0] perf_seg_q, perf_stall_q;

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn || perf_clr) begin
      perf_seg_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (out_acc && perf_seg_q != '1) perf_seg_q <= perf_seg_q + 32'd1;
      if (hold_vld_q && !out_prdy && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_seg_cnt   = perf_seg_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: doc/nv_nvdla_sdp_core_varpack.md
NV_NVDLA_SDP_CORE_VARPACK -- requirements
Module: NV_NVDLA_SDP_CORE_varpack

Interface
REQ-001 SHALL have parameter IW, default 512, input word width in bits.
REQ-002 SHALL have parameter OW, default 128, output segment width in bits.
REQ-003 SHALL derive NSEG=IW/OW and CW=max(1,clog2(NSEG)); IW%OW!=0 or NSEG not in {1,2,4,8,16} SHALL be an elaboration error.
REQ-004 SHALL have one clock and a synchronous active-low reset, with ports nvdla_core_clk and nvdla_core_rstn.
REQ-005 nvdla_core_clk  input  1  block clock; all state updates on rising edge.
REQ-006 nvdla_core_rstn  input  1  synchronous active-low reset.
REQ-007 inp_pvld  input  1  input word valid.
REQ-008 inp_prdy  output  1  input word ready.
REQ-009 inp_data  input  IW  input word; segment s = bits [OW*s+OW-1 : OW*s].
REQ-010 inp_nseg  input  CW+1  valid segments in the word: 1..NSEG; 0 or >NSEG means NSEG.
REQ-011 inp_msb_first  input  1  emit order: 0 = segment 0 first, 1 = highest valid segment first.
REQ-012 out_pvld  output  1  output segment valid.
REQ-013 out_prdy  input  1  output segment ready.
REQ-014 out_data  output  OW  current segment.
REQ-015 out_idx  output  CW  segment index of out_data within its source word.
REQ-016 out_last  output  1  high on the final segment of the held word.

Function
REQ-017 SHALL hold one word plus its nseg (clamped per REQ-010) and msb_first, captured on inp_acc = inp_pvld & inp_prdy.
REQ-018 inp_prdy SHALL be (!hold_vld) | (out_prdy & out_last); it is independent of inp_pvld.
REQ-019 out_pvld SHALL equal hold_vld; out_data, out_idx and out_last are combinational from held state and beat counter cnt.
REQ-020 On inp_prdy, hold_vld SHALL load inp_pvld; a word accepted on the last-segment handshake SHALL produce its first segment next cycle (no bubble).
REQ-021 cnt SHALL be 0 after capture; on out_acc it SHALL increment, or return to 0 when out_last.
REQ-022 out_idx SHALL be cnt when msb_first=0 and nseg-1-cnt when msb_first=1; out_last SHALL be (cnt==nseg-1).
REQ-023 Segments at or above nseg SHALL never be emitted; nseg=1 SHALL give a one-beat pass-through of segment 0.
REQ-024 While out_pvld & !out_prdy, out_data, out_idx and out_last SHALL stay stable.
REQ-025 out_data SHALL be all zeros while out_pvld=0.
REQ-026 Latency SHALL be one cycle from inp_acc to the first out_pvld; throughput SHALL be one segment per cycle.

Reset
REQ-027 With nvdla_core_rstn low at a rising edge: hold_vld=0, cnt=0, held nseg=NSEG, msb_first=0; held data need not reset.
REQ-028 The outputs after reset SHALL be: out_pvld=0, inp_prdy=1, out_data=0, out_idx=0, out_last=0.
REQ-029 Reset mid-word SHALL discard the remaining segments with no partial emission after release.
REQ-030 Reset SHALL have no asynchronous effect.

Configuration
REQ-031 Macro NVDLA_SDP_VARPACK_PERF_EN SHALL add the input perf_clr (1) and the outputs perf_seg_cnt (32) and perf_stall_cnt (32).
REQ-032 With the macro: perf_seg_cnt increments on out_acc; perf_stall_cnt increments each cycle out_pvld & !out_prdy.
REQ-033 Both counters SHALL saturate at 0xFFFFFFFF and reset to 0.
REQ-034 perf_clr SHALL synchronously clear both counters and take priority over a same-cycle increment.
REQ-035 Without the macro, the perf ports and their logic SHALL be absent and function SHALL be otherwise identical.

Verification
REQ-036 IW=512/OW=128, word segs {A0,A1,A2,A3}, nseg=4, msb_first=0, out_prdy=1 -> A0,A1,A2,A3 on 4 consecutive cycles, idx 0..3, out_last on A3 only.
REQ-037 Same word, nseg=3, msb_first=1 -> A2,A1,A0, idx 2,1,0, out_last on A0; A3 never emitted.
REQ-038 Two words back-to-back, nseg=2 each, out_prdy=1 -> 4 beats with no gap; inp_prdy high exactly on reset-exit and on each out_last cycle.
REQ-039 out_prdy low 3 cycles mid-word -> outputs frozen; perf_stall_cnt +3 with macro defined.
REQ-040 nseg=0, then nseg=7 -> 4 segments each (clamp); nseg=1 -> one beat, out_last=1, idx 0.
REQ-041 Reset asserted after 2 of 4 segments -> next cycle out_pvld=0, inp_prdy=1; no residual segments after release; perf_clr together with a stall -> counters read 0.
